ws2812_rx: RTL and testbench
============================

Name: ws2812_rx

Overview:
- Decodes a WS2812 single-wire serial stream back into addressed RGB pixels. It is the receiving end of the strip_ws2812 transmitter.
- Used for loopback self-test of the cape: a STRIP_o output is jumpered back to an input, and the decoded pixels are compared against the LCD source.
- Runs on the LED clock domain. Timing thresholds are expressed in clock cycles.

Parameters:
- LED_COUNT, 320, number of pixels accepted per frame; pixels past this are discarded and flagged.
- BIT_THRESHOLD, 11, high-pulse length in cycles at or above which a bit decodes as 1.
- HIGH_MAX, 30, high-pulse length in cycles beyond which the pulse is a glitch error.
- RESET_CYCLES, 1000, continuous low in cycles that ends a frame (latch).
- Defaults assume a 20 MHz led_clk_i: a 0 bit is about 7 cycles high, a 1 bit about 14, and latch is 50 us.

Ports:
- led_clk_i  in  1  sole clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- led_data_i  in  1  raw serial input, asynchronous to led_clk_i.
- pixel_r_o  out  8  decoded red.
- pixel_g_o  out  8  decoded green.
- pixel_b_o  out  8  decoded blue.
- led_address_o  out  10  pixel index within the frame, 0-based.
- pixel_valid_o  out  1  one-cycle strobe; RGB and address are valid only in this cycle.
- frame_done_o  out  1  one-cycle strobe when a latch gap ends a frame.
- frame_pixels_o  out  11  pixels received in the frame just ended; valid with frame_done_o, held until the next frame_done_o.
- overflow_o  out  1  sticky; a pixel arrived with index >= LED_COUNT. Cleared at the next frame start.
- bit_error_o  out  1  one-cycle strobe on a glitch or a partial pixel.

Behaviour:
- Reset: every output is 0, state is SYNC, all counters are 0, and the shift register is 0.
- Input path:
  - 2-flop synchronizer, then one edge register.
  - Rise and fall are detected in the cycle the edge register differs from the synchronizer output.
- States: SYNC, IDLE, HIGH, LOW.
- SYNC:
  - Counts consecutive low cycles; any high sample clears the count.
  - When the count reaches RESET_CYCLES, go to IDLE with address and bit count 0.
  - SYNC emits nothing, and reaching RESET_CYCLES here does not pulse frame_done_o.
- IDLE:
  - A rise goes to HIGH with high_cnt = 1.
  - Also clears overflow_o and the frame pixel counter.
- HIGH:
  - high_cnt increments each cycle and saturates at HIGH_MAX+1.
  - If high_cnt exceeds HIGH_MAX: pulse bit_error_o and go to SYNC. The partial pixel is dropped and frame_done_o is not pulsed.
  - On a fall: bit = (high_cnt >= BIT_THRESHOLD); shift it in MSB-first; increment bit_cnt; go to LOW with low_cnt = 1.
- Pixel completion, when bit_cnt reaches 24:
  - Wire order is G[7:0], R[7:0], B[7:0].
  - If address < LED_COUNT: in the next cycle drive RGB and address and pulse pixel_valid_o. Otherwise set overflow_o and emit nothing.
  - Then increment the address (saturates at 1023), increment the pixel counter (saturates at 2047), and reset bit_cnt to 0.
  - Latency: pixel_valid_o rises exactly 4 led_clk_i cycles after the raw falling edge of the 24th bit (2 sync + 1 edge + 1 output register).
- LOW:
  - low_cnt increments and saturates at RESET_CYCLES.
  - A rise goes to HIGH. A low gap of any length below RESET_CYCLES is legal.
  - When low_cnt reaches RESET_CYCLES, the frame ends:
    - If bit_cnt != 0, pulse bit_error_o in the same cycle as frame_done_o.
    - Pulse frame_done_o; load frame_pixels_o with the pixel count; reset address and bit_cnt; go to IDLE.
- Simultaneous events:
  - A pixel completion and the frame end cannot coincide, because completion occurs on a fall and the frame end requires RESET_CYCLES of low.
  - A glitch error takes priority over all other actions in the same cycle.
- Asynchronous reset mid-frame: immediate clear. After release, the block must see a full low gap in SYNC before it decodes anything.
- Arithmetic is unsigned throughout. Counters are sized as clog2(param+2) bits.

Decomposition:
- Shared package medusa_ws2812_pkg, holding:
  - BITS_PER_PIXEL = 24;
  - the GRB byte-offset constants;
  - the state encoding;
  - the default timing constants, shared with strip_ws2812 so TX and RX agree.
- One sub-module, ws2812_rx_sync: the 2-flop synchronizer plus edge register, outputting level, rise and fall.
- The FSM, counters and shift register stay in ws2812_rx.

Test Plan:
- Reset, then 1000 low cycles, then 3 pixels G=0x12 R=0x34 B=0x56, G=0xFF R=0x00 B=0x80, G=0x00 R=0x00 B=0x01 (7/14-cycle highs, 25-cycle bit periods), then 1000 low cycles:
  - 3 pixel_valid_o strobes at addresses 0, 1, 2 with those RGB values;
  - each strobe 4 cycles after the 24th fall;
  - frame_done_o with frame_pixels_o = 3.
- Highs of 10 and 11 cycles: decode as 0 and 1 respectively (threshold edge).
- LED_COUNT=2, send 3 pixels:
  - 2 strobes; overflow_o set; frame_pixels_o = 3;
  - the next frame's first rise clears overflow_o.
- Send 12 bits, then 1000 low cycles: frame_done_o and bit_error_o pulse in the same cycle; frame_pixels_o = 0.
- A 31-cycle high mid-pixel: bit_error_o pulses, no frame_done_o, and pixels are ignored until a 1000-cycle low gap has passed.
- Assert rst_n_i mid-pixel and release it, then immediately send a pixel without a prior gap:
  - no pixel_valid_o;
  - after a 1000-cycle gap, the next frame decodes from address 0.

Source files
------------

// File: rtl/medusa_ws2812_pkg.sv
// Shared WS2812 definitions: pixel layout, receiver state encoding and the
// default timing constants used by both the strip transmitter and receiver.
package medusa_ws2812_pkg;

   localparam int BITS_PER_PIXEL = 24;

   // Byte offsets within a received word; the wire order is G, R, B, MSB first.
   localparam int G_OFFSET = 16;
   localparam int R_OFFSET = 8;
   localparam int B_OFFSET = 0;

   localparam int DEFAULT_LED_COUNT     = 320;
   localparam int DEFAULT_BIT_THRESHOLD = 11;
   localparam int DEFAULT_HIGH_MAX      = 30;
   localparam int DEFAULT_RESET_CYCLES  = 1000;
   localparam int DEFAULT_T0H           = 7;
   localparam int DEFAULT_T1H           = 14;
   localparam int DEFAULT_BIT_PERIOD    = 25;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } rx_state_t;

   function automatic logic [7:0] grb_byte(input logic [BITS_PER_PIXEL-1:0] word,
                                           input int unsigned offset);
      return 8'(word >> offset);
   endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// Brings the asynchronous serial line into the LED clock domain and reports
// the synchronised level together with single-cycle rise and fall flags.
module ws2812_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic edge_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         meta   <= din;
         sync_q <= meta;
         edge_q <= sync_q;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~edge_q;
   assign fall  = ~sync_q & edge_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high-pulse widths to recover bits, assembles GRB
// pixels and reports per-pixel strobes, frame boundaries and framing errors.
module ws2812_rx
   import medusa_ws2812_pkg::*;
#(
   parameter int LED_COUNT     = DEFAULT_LED_COUNT,
   parameter int BIT_THRESHOLD = DEFAULT_BIT_THRESHOLD,
   parameter int HIGH_MAX      = DEFAULT_HIGH_MAX,
   parameter int RESET_CYCLES  = DEFAULT_RESET_CYCLES
) (
   input  logic        led_clk_i,
   input  logic        rst_n_i,
   input  logic        led_data_i,
   output logic [7:0]  pixel_r_o,
   output logic [7:0]  pixel_g_o,
   output logic [7:0]  pixel_b_o,
   output logic [9:0]  led_address_o,
   output logic        pixel_valid_o,
   output logic        frame_done_o,
   output logic [10:0] frame_pixels_o,
   output logic        overflow_o,
   output logic        bit_error_o
);

   localparam int LOW_W  = $clog2(RESET_CYCLES + 2);
   localparam int HIGH_W = $clog2(HIGH_MAX + 2);
   localparam int BIT_W  = $clog2(BITS_PER_PIXEL + 2);

   localparam logic [LOW_W-1:0]  LOW_LIMIT  = LOW_W'(RESET_CYCLES);
   localparam logic [LOW_W-1:0]  LOW_ONE    = LOW_W'(1);
   localparam logic [HIGH_W-1:0] HIGH_LIMIT = HIGH_W'(HIGH_MAX);
   localparam logic [HIGH_W-1:0] HIGH_SAT   = HIGH_W'(HIGH_MAX + 1);
   localparam logic [HIGH_W-1:0] HIGH_ONE   = HIGH_W'(1);
   localparam logic [HIGH_W-1:0] BIT_THR    = HIGH_W'(BIT_THRESHOLD);
   localparam logic [BIT_W-1:0]  BITS_FULL  = BIT_W'(BITS_PER_PIXEL);
   localparam logic [11:0]       LED_LIMIT  = 12'(LED_COUNT);

   rx_state_t state;
   rx_state_t next_state;

   logic level;
   logic rise;
   logic fall;

   logic [LOW_W-1:0]          low_cnt;
   logic [HIGH_W-1:0]         high_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic [9:0]                address;
   logic [10:0]               pix_cnt;
   logic [BITS_PER_PIXEL-1:0] shift;
   logic                      bit_value;

   logic sync_done;
   logic frame_start;
   logic go_high;
   logic take_bit;
   logic glitch;
   logic frame_end;

   ws2812_rx_sync u_sync (
      .clk   (led_clk_i),
      .rst_n (rst_n_i),
      .din   (led_data_i),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   assign bit_value = (high_cnt >= BIT_THR);

   always_ff @(posedge led_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_SYNC;
      end else begin
         state <= next_state;
      end
   end

   // An over-long high wins over a coincident fall; the frame end wins over a
   // rise that lands exactly on the latch boundary.
   always_comb begin
      next_state  = state;
      sync_done   = 1'b0;
      frame_start = 1'b0;
      go_high     = 1'b0;
      take_bit    = 1'b0;
      glitch      = 1'b0;
      frame_end   = 1'b0;
      case (state)
         ST_SYNC: begin
            if (low_cnt == LOW_LIMIT) begin
               sync_done  = 1'b1;
               next_state = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (rise) begin
               frame_start = 1'b1;
               next_state  = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (high_cnt > HIGH_LIMIT) begin
               glitch     = 1'b1;
               next_state = ST_SYNC;
            end else if (fall) begin
               take_bit   = 1'b1;
               next_state = ST_LOW;
            end
         end
         ST_LOW: begin
            if (low_cnt == LOW_LIMIT) begin
               frame_end  = 1'b1;
               next_state = ST_IDLE;
            end else if (rise) begin
               go_high    = 1'b1;
               next_state = ST_HIGH;
            end
         end
         default: next_state = ST_SYNC;
      endcase
   end

   always_ff @(posedge led_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         low_cnt        <= '0;
         high_cnt       <= '0;
         bit_cnt        <= '0;
         address        <= '0;
         pix_cnt        <= '0;
         shift          <= '0;
         pixel_r_o      <= '0;
         pixel_g_o      <= '0;
         pixel_b_o      <= '0;
         led_address_o  <= '0;
         pixel_valid_o  <= 1'b0;
         frame_done_o   <= 1'b0;
         frame_pixels_o <= '0;
         overflow_o     <= 1'b0;
         bit_error_o    <= 1'b0;
      end else begin
         pixel_valid_o <= 1'b0;
         frame_done_o  <= 1'b0;
         bit_error_o   <= 1'b0;
         if (glitch) begin
            bit_error_o <= 1'b1;
            bit_cnt     <= '0;
            low_cnt     <= '0;
         end else begin
            if (state == ST_SYNC) begin
               if (sync_done) begin
                  low_cnt <= '0;
                  address <= '0;
                  bit_cnt <= '0;
               end else if (level) begin
                  low_cnt <= '0;
               end else begin
                  low_cnt <= low_cnt + 1'b1;
               end
            end
            if (frame_start) begin
               high_cnt   <= HIGH_ONE;
               overflow_o <= 1'b0;
               pix_cnt    <= '0;
            end
            if (go_high) begin
               high_cnt <= HIGH_ONE;
            end
            if (state == ST_HIGH && !take_bit && high_cnt != HIGH_SAT) begin
               high_cnt <= high_cnt + 1'b1;
            end
            if (take_bit) begin
               shift   <= {shift[BITS_PER_PIXEL-2:0], bit_value};
               bit_cnt <= bit_cnt + 1'b1;
               low_cnt <= LOW_ONE;
            end
            if (state == ST_LOW && !go_high && !frame_end && low_cnt != LOW_LIMIT) begin
               low_cnt <= low_cnt + 1'b1;
            end
            if (frame_end) begin
               frame_done_o   <= 1'b1;
               bit_error_o    <= (bit_cnt != '0);
               frame_pixels_o <= pix_cnt;
               address        <= '0;
               bit_cnt        <= '0;
            end
            // The pixel completes the cycle after its 24th fall is taken,
            // which gives the extra output-register stage of latency.
            if (bit_cnt == BITS_FULL) begin
               if ({2'b00, address} < LED_LIMIT) begin
                  pixel_valid_o <= 1'b1;
                  pixel_r_o     <= grb_byte(shift, R_OFFSET);
                  pixel_g_o     <= grb_byte(shift, G_OFFSET);
                  pixel_b_o     <= grb_byte(shift, B_OFFSET);
                  led_address_o <= address;
               end else begin
                  overflow_o <= 1'b1;
               end
               if (address != '1) begin
                  address <= address + 1'b1;
               end
               if (pix_cnt != '1) begin
                  pix_cnt <= pix_cnt + 1'b1;
               end
               bit_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: a full-size receiver and a two-pixel
// receiver share one serial line and are checked against a frame-level model.
module tb_ws2812_rx;
   import medusa_ws2812_pkg::*;

   localparam int SMALL_COUNT = 2;
   localparam int GAP         = DEFAULT_RESET_CYCLES + 20;

   typedef enum int {EV_PIXEL, EV_FRAME, EV_ERROR} ev_kind_t;

   typedef struct {
      ev_kind_t    kind;
      int          addr;
      logic [23:0] rgb;
      int          cyc;
      int          pixels;
      bit          err;
      bit          ovf;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic data;

   logic [7:0]  r_a, g_a, b_a, r_s, g_s, b_s;
   logic [9:0]  addr_a, addr_s;
   logic        valid_a, valid_s, done_a, done_s, ovf_a, ovf_s, err_a, err_s;
   logic [10:0] fp_a, fp_s;

   int cycle = 0;
   int tests = 0;
   int fails = 0;

   ev_t exp_q0[$];
   ev_t exp_q1[$];

   bit          synced = 1'b0;
   int          npix = 0;
   int          nbits = 0;
   logic [23:0] cur_rgb = '0;
   bit          check_ovf_on_rise = 1'b0;

   ws2812_rx dut_a (
      .led_clk_i     (clk),
      .rst_n_i       (rst_n),
      .led_data_i    (data),
      .pixel_r_o     (r_a),
      .pixel_g_o     (g_a),
      .pixel_b_o     (b_a),
      .led_address_o (addr_a),
      .pixel_valid_o (valid_a),
      .frame_done_o  (done_a),
      .frame_pixels_o(fp_a),
      .overflow_o    (ovf_a),
      .bit_error_o   (err_a)
   );

   ws2812_rx #(.LED_COUNT(SMALL_COUNT)) dut_s (
      .led_clk_i     (clk),
      .rst_n_i       (rst_n),
      .led_data_i    (data),
      .pixel_r_o     (r_s),
      .pixel_g_o     (g_s),
      .pixel_b_o     (b_s),
      .led_address_o (addr_s),
      .pixel_valid_o (valid_s),
      .frame_done_o  (done_s),
      .frame_pixels_o(fp_s),
      .overflow_o    (ovf_s),
      .bit_error_o   (err_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   function automatic int lcOf(input int d);
      return (d == 0) ? DEFAULT_LED_COUNT : SMALL_COUNT;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      tests++;
      if (actual !== required) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, required, cycle);
      end
   endtask

   task automatic pushEvent(input int d, input ev_t e);
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic popEvent(input int d, output ev_t e, output bit have);
      have = 1'b0;
      e    = '{EV_ERROR, 0, '0, 0, 0, 1'b0, 1'b0};
      if (d == 0 && exp_q0.size() > 0) begin
         e = exp_q0.pop_front();
         have = 1'b1;
      end else if (d == 1 && exp_q1.size() > 0) begin
         e = exp_q1.pop_front();
         have = 1'b1;
      end
   endtask

   // Any strobe from either receiver must match the oldest outstanding event.
   task automatic monitorDut(input int d, input logic pv, input logic fd,
                             input logic be, input logic ov,
                             input logic [9:0] addr, input logic [23:0] rgb,
                             input logic [10:0] fp);
      ev_t      e;
      bit       have;
      ev_kind_t obs;
      string    tag;
      if (!(pv || fd || be)) return;
      tag = (d == 0) ? "full" : "small";
      obs = fd ? EV_FRAME : (pv ? EV_PIXEL : EV_ERROR);
      popEvent(d, e, have);
      checkOutput({tag, "_event_expected"}, 64'(have), 64'd1);
      if (!have) return;
      checkOutput({tag, "_event_kind"}, 64'(obs), 64'(e.kind));
      if (obs != e.kind) return;
      case (e.kind)
         EV_PIXEL: begin
            checkOutput({tag, "_pixel_addr"}, 64'(addr), 64'(e.addr));
            checkOutput({tag, "_pixel_rgb"}, 64'(rgb), 64'(e.rgb));
            checkOutput({tag, "_pixel_latency"}, 64'(cycle), 64'(e.cyc));
         end
         EV_FRAME: begin
            checkOutput({tag, "_frame_pixels"}, 64'(fp), 64'(e.pixels));
            checkOutput({tag, "_frame_bit_error"}, 64'(be), 64'(e.err));
            checkOutput({tag, "_frame_overflow"}, 64'(ov), 64'(e.ovf));
         end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      monitorDut(0, valid_a, done_a, err_a, ovf_a, addr_a, {r_a, g_a, b_a}, fp_a);
      monitorDut(1, valid_s, done_s, err_s, ovf_s, addr_s, {r_s, g_s, b_s}, fp_s);
   end

   // mode 0: nominal 7/14 highs in 25-cycle periods; 1: threshold edge
   // widths 10/11; otherwise random legal widths and gaps.
   task automatic applyStimulus(input bit b, input int mode);
      int hi;
      int lo;
      ev_t e;
      case (mode)
         0: begin
            hi = b ? DEFAULT_T1H : DEFAULT_T0H;
            lo = DEFAULT_BIT_PERIOD - hi;
         end
         1: begin
            hi = b ? DEFAULT_BIT_THRESHOLD : DEFAULT_BIT_THRESHOLD - 1;
            lo = 14;
         end
         default: begin
            hi = b ? int'($urandom_range(20, DEFAULT_BIT_THRESHOLD))
                   : int'($urandom_range(DEFAULT_BIT_THRESHOLD - 1, 5));
            lo = int'($urandom_range(20, 3));
         end
      endcase
      data = 1'b1;
      for (int i = 1; i <= hi; i++) begin
         @(negedge clk);
         if (check_ovf_on_rise && i == 4) begin
            checkOutput("full_ovf_cleared_on_rise", 64'(ovf_a), 64'd0);
            checkOutput("small_ovf_cleared_on_rise", 64'(ovf_s), 64'd0);
            check_ovf_on_rise = 1'b0;
         end
      end
      data = 1'b0;
      nbits++;
      if (nbits == BITS_PER_PIXEL) begin
         if (synced) begin
            for (int d = 0; d < 2; d++) begin
               if (npix < lcOf(d)) begin
                  e = '{EV_PIXEL, npix, cur_rgb, cycle + 4, 0, 1'b0, 1'b0};
                  pushEvent(d, e);
               end
            end
         end
         npix++;
         nbits = 0;
      end
      repeat (lo) @(negedge clk);
   endtask

   task automatic sendPixel(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input int mode);
      logic [23:0] grb_word;
      grb_word = {g, r, b};
      cur_rgb  = {r, g, b};
      for (int i = 23; i >= 0; i--) applyStimulus(grb_word[i], mode);
   endtask

   task automatic sendRandomPixel();
      sendPixel(8'($urandom), 8'($urandom), 8'($urandom), 2);
   endtask

   task automatic sendPartial(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'($urandom), 2);
   endtask

   task automatic endFrame();
      ev_t e;
      if (synced) begin
         for (int d = 0; d < 2; d++) begin
            e = '{EV_FRAME, 0, '0, 0, (npix > 2047) ? 2047 : npix,
                  (nbits != 0), (npix > lcOf(d))};
            pushEvent(d, e);
         end
      end
      npix  = 0;
      nbits = 0;
      data  = 1'b0;
      repeat (GAP) @(negedge clk);
      synced = 1'b1;
   endtask

   task automatic glitchPulse();
      ev_t e;
      if (synced) begin
         e = '{EV_ERROR, 0, '0, 0, 0, 1'b1, 1'b0};
         pushEvent(0, e);
         pushEvent(1, e);
      end
      synced = 1'b0;
      npix   = 0;
      nbits  = 0;
      data   = 1'b1;
      repeat (DEFAULT_HIGH_MAX + 1) @(negedge clk);
      data = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, 64'({valid_a, valid_s}), 64'd0);
      checkOutput({tag, "_done"}, 64'({done_a, done_s}), 64'd0);
      checkOutput({tag, "_bit_error"}, 64'({err_a, err_s}), 64'd0);
      checkOutput({tag, "_overflow"}, 64'({ovf_a, ovf_s}), 64'd0);
      checkOutput({tag, "_frame_pixels"}, 64'({fp_a, fp_s}), 64'd0);
      checkOutput({tag, "_address"}, 64'({addr_a, addr_s}), 64'd0);
      checkOutput({tag, "_rgb"}, 64'({r_a, g_a, b_a, r_s, g_s, b_s}), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      data  = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("por");
      rst_n = 1'b1;
      endFrame();

      sendPixel(8'h34, 8'h12, 8'h56, 0);
      sendPixel(8'h00, 8'hFF, 8'h80, 0);
      sendPixel(8'h00, 8'h00, 8'h01, 0);
      endFrame();
      checkOutput("full_frame_pixels_held", 64'(fp_a), 64'd3);
      checkOutput("small_ovf_held_until_rise", 64'(ovf_s), 64'd1);

      check_ovf_on_rise = 1'b1;
      sendPixel(8'hA5, 8'h5A, 8'h3C, 1);
      sendPixel(8'($urandom), 8'($urandom), 8'($urandom), 1);
      endFrame();

      for (int k = 0; k < 4; k++) begin
         int n;
         n = int'($urandom_range(4, 1));
         for (int p = 0; p < n; p++) sendRandomPixel();
         if (k == 2) sendPartial(5);
         endFrame();
      end

      sendPartial(12);
      endFrame();

      sendRandomPixel();
      sendPartial(5);
      glitchPulse();
      sendRandomPixel();
      endFrame();
      sendRandomPixel();
      sendRandomPixel();
      endFrame();

      sendRandomPixel();
      sendPartial(12);
      rst_n  = 1'b0;
      synced = 1'b0;
      npix   = 0;
      nbits  = 0;
      repeat (3) @(negedge clk);
      checkResetOutputs("midframe_reset");
      rst_n = 1'b1;
      sendRandomPixel();
      endFrame();
      sendRandomPixel();
      sendRandomPixel();
      sendRandomPixel();
      endFrame();

      repeat (20) @(negedge clk);
      checkOutput("full_events_outstanding", 64'(exp_q0.size()), 64'd0);
      checkOutput("small_events_outstanding", 64'(exp_q1.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #(100000 * 10);
      $display("[TB] FAIL watchdog: run exceeded 100000 cycles, got cycle %0d", cycle);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
